// File: rtl/rename_ckpt_unit.sv
// Single-issue register rename with a circular free list and branch checkpoints.
// Optional build macro REN_PERF_EN adds a saturating stall-cycle counter output.
module rename_ckpt_unit #(
   parameter int ARCH_REGS = 32,
   parameter int AREG_W    = 5,
   parameter int PHYS_REGS = 64,
   parameter int PREG_W    = 6,
   parameter int NUM_CKPT  = 4,
   parameter int CKPT_W    = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ren_valid_IN,
   input  logic [AREG_W-1:0] ren_src1_IN,
   input  logic [AREG_W-1:0] ren_src2_IN,
   input  logic [AREG_W-1:0] ren_dst_IN,
   input  logic              ren_dstEn_IN,
   input  logic              ren_ckpt_IN,
   input  logic              stall_IN,
   output logic              ren_ready_OUT,
   output logic              out_valid_OUT,
   output logic [PREG_W-1:0] out_psrc1_OUT,
   output logic [PREG_W-1:0] out_psrc2_OUT,
   output logic [PREG_W-1:0] out_pdst_OUT,
   output logic [PREG_W-1:0] out_pold_OUT,
   output logic [CKPT_W-1:0] out_ckptId_OUT,
   output logic              out_hasCkpt_OUT,
   input  logic              commit_free_IN,
   input  logic [PREG_W-1:0] commit_preg_IN,
   input  logic              recover_IN,
   input  logic [CKPT_W-1:0] recover_ckptId_IN,
   input  logic              release_IN,
   output logic [PREG_W:0]   freeCount_OUT
`ifdef REN_PERF_EN
   ,
   output logic [31:0]       stallCycles_OUT
`endif
);

   localparam logic [PREG_W:0] P_ONE      = (PREG_W+1)'(1);
   localparam logic [PREG_W:0] P_INIT_CNT = (PREG_W+1)'(PHYS_REGS - ARCH_REGS);
   localparam logic [CKPT_W-1:0] C_ONE    = CKPT_W'(1);
   localparam logic [CKPT_W:0] CC_ONE     = (CKPT_W+1)'(1);
   localparam logic [CKPT_W:0] CC_FULL    = (CKPT_W+1)'(NUM_CKPT);

   logic [PREG_W-1:0] map_q    [ARCH_REGS];
   logic [PREG_W-1:0] fl_q     [PHYS_REGS];
   logic [PREG_W-1:0] ck_map_q [NUM_CKPT][ARCH_REGS];
   logic [PREG_W:0]   ck_head_q[NUM_CKPT];

   logic [PREG_W:0]   head_q, head_d;
   logic [PREG_W:0]   tail_q, tail_d;
   logic [PREG_W:0]   count;
   logic [CKPT_W-1:0] alloc_q, alloc_d;
   logic [CKPT_W-1:0] oldest_q, oldest_d;
   logic [CKPT_W:0]   ck_cnt_q, ck_cnt_d;

   logic              out_valid_q;
   logic [PREG_W-1:0] out_psrc1_q, out_psrc2_q, out_pdst_q, out_pold_q;
   logic [CKPT_W-1:0] out_ckptId_q;
   logic              out_hasCkpt_q;

   logic              dst_en, ck_full, fire, pop, ck_push, rel_en;
   logic [PREG_W-1:0] new_preg;

   // Occupancy uses the extra wrap bit so a completely full list reads as PHYS_REGS.
   assign count    = tail_q - head_q;
   assign dst_en   = ren_dstEn_IN && (ren_dst_IN != '0);
   assign ck_full  = (ck_cnt_q == CC_FULL);
   assign new_preg = fl_q[head_q[PREG_W-1:0]];

   assign ren_ready_OUT = RESET && !recover_IN && !stall_IN &&
                          (!dst_en || (count != '0)) &&
                          (!ren_ckpt_IN || !ck_full);

   assign fire    = ren_valid_IN && ren_ready_OUT;
   assign pop     = fire && dst_en;
   assign ck_push = fire && ren_ckpt_IN;
   assign rel_en  = release_IN && (ck_cnt_q != '0);

   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      alloc_d  = alloc_q;
      oldest_d = oldest_q;
      ck_cnt_d = ck_cnt_q;
      if (commit_free_IN) begin
         tail_d = tail_q + P_ONE;
      end
      // Release is applied before recovery so the surviving-slot count is
      // measured from the post-release oldest slot.
      if (rel_en) begin
         oldest_d = oldest_q + C_ONE;
         ck_cnt_d = ck_cnt_q - CC_ONE;
      end
      if (recover_IN) begin
         head_d   = ck_head_q[recover_ckptId_IN];
         alloc_d  = recover_ckptId_IN + C_ONE;
         ck_cnt_d = {1'b0, CKPT_W'(recover_ckptId_IN - oldest_d)} + CC_ONE;
      end else begin
         if (pop) begin
            head_d = head_q + P_ONE;
         end
         if (ck_push) begin
            alloc_d  = alloc_q + C_ONE;
            ck_cnt_d = ck_cnt_d + CC_ONE;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         head_q   <= '0;
         tail_q   <= P_INIT_CNT;
         alloc_q  <= '0;
         oldest_q <= '0;
         ck_cnt_q <= '0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         alloc_q  <= alloc_d;
         oldest_q <= oldest_d;
         ck_cnt_q <= ck_cnt_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            map_q[i] <= PREG_W'(i);
         end
         for (int j = 0; j < PHYS_REGS; j++) begin
            fl_q[j] <= (j < PHYS_REGS - ARCH_REGS) ? PREG_W'(j + ARCH_REGS) : '0;
         end
      end else begin
         if (commit_free_IN) begin
            fl_q[tail_q[PREG_W-1:0]] <= commit_preg_IN;
         end
         if (recover_IN) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
               map_q[i] <= ck_map_q[recover_ckptId_IN][i];
            end
         end else if (pop) begin
            map_q[ren_dst_IN] <= new_preg;
         end
      end
   end

   // Snapshot includes this branch's own destination update and post-pop head.
   always_ff @(posedge CLK) begin
      if (ck_push) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            ck_map_q[alloc_q][i] <= (pop && (ren_dst_IN == AREG_W'(i))) ? new_preg : map_q[i];
         end
         ck_head_q[alloc_q] <= pop ? (head_q + P_ONE) : head_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         out_valid_q   <= 1'b0;
         out_psrc1_q   <= '0;
         out_psrc2_q   <= '0;
         out_pdst_q    <= '0;
         out_pold_q    <= '0;
         out_ckptId_q  <= '0;
         out_hasCkpt_q <= 1'b0;
      end else begin
         out_valid_q <= fire;
         if (fire) begin
            out_psrc1_q   <= map_q[ren_src1_IN];
            out_psrc2_q   <= map_q[ren_src2_IN];
            out_pdst_q    <= pop ? new_preg : '0;
            out_pold_q    <= pop ? map_q[ren_dst_IN] : '0;
            out_ckptId_q  <= ren_ckpt_IN ? alloc_q : '0;
            out_hasCkpt_q <= ren_ckpt_IN;
         end
      end
   end

   assign out_valid_OUT   = out_valid_q;
   assign out_psrc1_OUT   = out_psrc1_q;
   assign out_psrc2_OUT   = out_psrc2_q;
   assign out_pdst_OUT    = out_pdst_q;
   assign out_pold_OUT    = out_pold_q;
   assign out_ckptId_OUT  = out_ckptId_q;
   assign out_hasCkpt_OUT = out_hasCkpt_q;
   assign freeCount_OUT   = count;

`ifdef REN_PERF_EN
   logic [31:0] stall_cyc_q;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         stall_cyc_q <= '0;
      end else if (ren_valid_IN && !ren_ready_OUT && !recover_IN && (stall_cyc_q != '1)) begin
         stall_cyc_q <= stall_cyc_q + 32'd1;
      end
   end

   assign stallCycles_OUT = stall_cyc_q;
`endif

endmodule

// File: doc/rename_ckpt_unit.md
# rename_ckpt_unit

Single-issue register rename unit with parametrised architectural and physical register counts and branch checkpoints. It owns the map table and the circular free list, and returns pointers to a checkpoint on misprediction recovery. It sits between the decode-rename queue and the IQ/LSQ/ROB dispatch logic. Freed physical registers come back from ROB commit.

## Interface
- ARCH_REGS, 32, architectural register count (power of 2)
- AREG_W, 5, log2(ARCH_REGS)
- PHYS_REGS, 64, physical register count (power of 2, > ARCH_REGS)
- PREG_W, 6, log2(PHYS_REGS)
- NUM_CKPT, 4, checkpoint slots (power of 2)
- CKPT_W, 2, log2(NUM_CKPT)

Ports:
- CLK  in  1  clock
- RESET  in  1  reset, synchronous, active-low
- ren_valid_IN  in  1  instruction offered
- ren_src1_IN, ren_src2_IN  in  AREG_W each  architectural sources
- ren_dst_IN  in  AREG_W  architectural destination
- ren_dstEn_IN  in  1  destination write required
- ren_ckpt_IN  in  1  instruction is a branch and needs a checkpoint
- stall_IN  in  1  downstream (IQ/LSQ/ROB) full
- ren_ready_OUT  out  1  rename accepts this cycle
- out_valid_OUT  out  1  renamed instruction valid
- out_psrc1_OUT, out_psrc2_OUT, out_pdst_OUT, out_pold_OUT  out  PREG_W each  physical sources, new destination, previous destination mapping (sent to the ROB)
- out_ckptId_OUT  out  CKPT_W  checkpoint slot allocated (valid when out_hasCkpt_OUT)
- out_hasCkpt_OUT  out  1  checkpoint was allocated
- commit_free_IN  in  1  return a physical register
- commit_preg_IN  in  PREG_W  register being returned
- recover_IN  in  1  mispredict; restore to checkpoint
- recover_ckptId_IN  in  CKPT_W  slot to restore
- release_IN  in  1  oldest checkpoint's branch resolved correct
- freeCount_OUT  out  PREG_W+1  free-list occupancy

## Operation
- Reset: map[i]=i; free list holds ARCH_REGS..PHYS_REGS-1 in ascending order.
  - Pointers: head=0, tail=PHYS_REGS-ARCH_REGS. Both are PREG_W+1 bits, with the extra bit used for wrap.
  - Checkpoint queue empty; all outputs 0; freeCount_OUT=PHYS_REGS-ARCH_REGS.
- Effective dest: dstEn = ren_dstEn_IN && ren_dst_IN!=0. Arch reg 0 is never renamed.
- ren_ready_OUT = RESET && !recover_IN && !stall_IN && (!dstEn || count>0) && (!ren_ckpt_IN || ckpt not full). This is combinational from registered state.
- A fire is ren_valid_IN && ren_ready_OUT. On fire:
  - psrcN = map[srcN]. Sources read the pre-update map, so src==dst gives the old mapping.
  - If dstEn: pdst = freelist[head], pold = map[dst], head++, map[dst]=pdst.
  - If not dstEn: pdst=0, pold=0.
  - If ren_ckpt_IN: slot = ckpt alloc pointer. The snapshot holds the map including this instruction's update, plus head after its pop. The alloc pointer then increments.
- commit_free_IN: freelist[tail]=commit_preg_IN, tail++. This is independent of rename, stall or recover.
- count = tail-head (PREG_W+1 arithmetic, wrap-safe). The free list array has PHYS_REGS entries, so it never overflows.
- recover_IN: map and head are restored from slot recover_ckptId_IN. The ckpt alloc pointer becomes recover_ckptId_IN+1, which discards all younger slots. tail is not restored. out_valid_OUT=0 next cycle.
- release_IN: the oldest checkpoint slot is freed. Release is issued in program order only.
  - release_IN together with recover_IN: release is applied first. It is legal only when the recovered slot is not the oldest.

## Timing
- Rename latency is 1 cycle: outputs are registered and update on the edge after a fire. out_valid_OUT drops to 0 on the cycle after a non-fire.
- Back-to-back dependent renames work at full rate: the map is written at the edge, and the next instruction reads it.
- A commit push and a rename pop may occur in the same cycle. The pushed register becomes poppable the next cycle (count is registered).
- A checkpoint allocated this cycle is recoverable from the next cycle.
- Applying RESET mid-operation discards all in-flight state and returns to the reset values above on the next edge.

## Configuration
- REN_PERF_EN:
  - Defined: adds output stallCycles_OUT (32-bit), cleared on reset.
  - It increments each cycle where ren_valid_IN && !ren_ready_OUT && !recover_IN, and saturates at all-ones.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- After reset, rename r1<-r2,r3 → psrc1=2, psrc2=3, pdst=32, pold=1, freeCount_OUT 32→31.
- Back-to-back r1<-r1, then r4<-r1 → second instruction gets psrc1=32 (first's pdst) and pdst=33.
- Rename 32 writes with no commits; the 33rd write → ren_ready_OUT=0. Then commit_free_IN preg 1 → ready the following cycle; the rename pops 1.
- Branch with ckpt (slot 0), then 3 writes (pdst 33,34,35), then recover_IN slot 0 → the next rename of r5 gets pdst=33 and map[r5] reverts.
- Fill 4 checkpoints; a 5th branch → ready=0 until release_IN; afterwards the slot id wraps to 0.
- Rename with ren_dst_IN=0 and ren_dstEn_IN=1 → pdst=0, head unchanged. With REN_PERF_EN, 5 stalled cycles → stallCycles_OUT=5.
